// File: rtl/mask_centroid_pkg.sv
// mask_centroid_pkg
//   Shared constants, FSM encoding and small helpers for the mask centroid
//   block and its serial divider.
//   No ports (package).
package mask_centroid_pkg;

  localparam int COORD_W  = 10;
  localparam int CNT_W    = 20;
  localparam int DIV_ITER = 32;

  localparam logic [COORD_W-1:0] BBOX_MIN_INIT = 10'h3FF;
  localparam logic [COORD_W-1:0] BBOX_MAX_INIT = 10'h000;
  localparam logic [COORD_W-1:0] COORD_MAX     = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV_X = 2'd1,
    ST_DIV_Y = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

  localparam bbox_t BBOX_INIT = '{
    x_min: BBOX_MIN_INIT,
    x_max: BBOX_MAX_INIT,
    y_min: BBOX_MIN_INIT,
    y_max: BBOX_MAX_INIT
  };

  // Coordinate counters stick at the top value instead of wrapping.
  function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
    if (v == COORD_MAX) begin
      return v;
    end else begin
      return v + COORD_W'(1);
    end
  endfunction

endpackage

// File: rtl/mask_centroid_serial_divider.sv
// mask_centroid_serial_divider
//   Restoring unsigned divider, one quotient bit per enabled clock.
//   The start cycle already performs the first iteration, so a full
//   division takes exactly DIVIDEND_W enabled cycles from start to done.
// Ports:
//   clk, rst (async active-low), ce (clock enable)
//   start     : load dividend/divisor and begin (must be idle)
//   dividend  : DIVIDEND_W-bit numerator
//   divisor   : DIVISOR_W-bit denominator (nonzero)
//   busy      : iterations still outstanding
//   done      : one enabled-cycle pulse, quotient/remainder valid
//   quotient  : DIVIDEND_W-bit result
//   remainder : DIVISOR_W-bit remainder
module mask_centroid_serial_divider
  import mask_centroid_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_ITER,
  parameter int DIVISOR_W  = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
);

  localparam int ITER_W = $clog2(DIVIDEND_W + 1);

  logic [ITER_W-1:0]     iter;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [DIVIDEND_W-1:0] q_in;
  logic [DIVIDEND_W-1:0] q_next;
  logic [DIVISOR_W-1:0]  r_in;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVISOR_W-1:0]  div_use;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;

  // One restoring step; quotient register doubles as the dividend shifter.
  always_comb begin
    if (start) begin
      q_in    = dividend;
      r_in    = '0;
      div_use = divisor;
    end else begin
      q_in    = quotient;
      r_in    = remainder;
      div_use = divisor_r;
    end
    trial = {r_in, q_in[DIVIDEND_W-1]};
    diff  = trial - {1'b0, div_use};
    if (trial >= {1'b0, div_use}) begin
      r_next = diff[DIVISOR_W-1:0];
      q_next = {q_in[DIVIDEND_W-2:0], 1'b1};
    end else begin
      r_next = trial[DIVISOR_W-1:0];
      q_next = {q_in[DIVIDEND_W-2:0], 1'b0};
    end
  end

  // Iteration counter, partial remainder and quotient shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter      <= '0;
      divisor_r <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      if (start || busy) begin
        quotient  <= q_next;
        remainder <= r_next;
        if (start) begin
          divisor_r <= divisor;
          iter      <= ITER_W'(1);
          busy      <= 1'b1;
        end else if (iter == ITER_W'(DIVIDEND_W - 1)) begin
          iter <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          iter <= iter + ITER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mask_centroid.sv
// mask_centroid
//   Binary-mask video sink. Per frame it accumulates the foreground pixel
//   count, coordinate sums and bounding box; at the vsync rising edge it
//   snapshots them, divides the sums by the count with one time-shared
//   serial divider and publishes one result set per frame.
// Ports:
//   clk, rst (async active-low), ce (clock enable, all state holds when 0)
//   mask, in_de, in_vsync, in_hsync : mask video stream (hsync unused)
//   count                           : foreground pixels of last frame
//   x_min, x_max, y_min, y_max      : bounding box of last frame
//   cx, cy                          : floor centroid of last frame
//   empty                           : last frame had no foreground
//   result_valid                    : pulse when outputs were updated
//   overrun                         : pulse when a frame end was dropped
module mask_centroid
  import mask_centroid_pkg::*;
#(
  parameter int H_SIZE = 83,
  parameter int V_SIZE = 64,
  parameter int SUM_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               mask,
  input  logic               in_de,
  input  logic               in_vsync,
  input  logic               in_hsync,
  output logic [CNT_W-1:0]   count,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               empty,
  output logic               result_valid,
  output logic               overrun
);

  logic               de_d;
  logic               vsync_d;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  logic [CNT_W-1:0]   acc_count;
  logic [CNT_W-1:0]   acc_count_upd;
  logic [SUM_W-1:0]   acc_sx;
  logic [SUM_W-1:0]   acc_sx_upd;
  logic [SUM_W-1:0]   acc_sy;
  logic [SUM_W-1:0]   acc_sy_upd;
  bbox_t              acc_bb;
  bbox_t              acc_bb_upd;

  logic [CNT_W-1:0]   sh_count;
  logic [SUM_W-1:0]   sh_sx;
  logic [SUM_W-1:0]   sh_sy;
  bbox_t              sh_bb;
  logic               pending;

  state_t             state;
  state_t             state_nxt;
  logic               div_start;
  logic [SUM_W-1:0]   div_dividend;
  logic               div_busy;
  logic               div_done;
  logic [SUM_W-1:0]   div_quotient;
  logic [CNT_W-1:0]   div_remainder;
  logic               cap_x;
  logic               cap_y;
  logic               publish;
  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cy_q;

  logic               pix;
  logic               frame_end;
  logic               accept;

  // Geometry parameters are descriptive; counters are sized for 1024.
  logic               misc_unused;
  assign misc_unused = ^{div_quotient[SUM_W-1:COORD_W], div_remainder, div_busy,
                         in_hsync, (H_SIZE > 0), (V_SIZE > 0)};

  assign pix       = ce & in_de & mask;
  assign frame_end = ce & in_vsync & ~vsync_d;
  // A snapshot is only taken when the previous one has been consumed.
  assign accept    = frame_end & (state == ST_IDLE) & ~pending;

  // Raster position tracking; vsync rise has priority over line stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_d    <= 1'b0;
      vsync_d <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else if (ce) begin
      de_d    <= in_de;
      vsync_d <= in_vsync;
      if (in_vsync && !vsync_d) begin
        x <= '0;
        y <= '0;
      end else if (in_de) begin
        x <= coord_sat_inc(x);
      end else if (de_d) begin
        x <= '0;
        y <= coord_sat_inc(y);
      end
    end
  end

  // Accumulator values including the current pixel (also fed to the snapshot).
  always_comb begin
    if (pix) begin
      acc_count_upd    = acc_count + CNT_W'(1);
      acc_sx_upd       = acc_sx + SUM_W'(x);
      acc_sy_upd       = acc_sy + SUM_W'(y);
      acc_bb_upd.x_min = (x < acc_bb.x_min) ? x : acc_bb.x_min;
      acc_bb_upd.x_max = (x > acc_bb.x_max) ? x : acc_bb.x_max;
      acc_bb_upd.y_min = (y < acc_bb.y_min) ? y : acc_bb.y_min;
      acc_bb_upd.y_max = (y > acc_bb.y_max) ? y : acc_bb.y_max;
    end else begin
      acc_count_upd = acc_count;
      acc_sx_upd    = acc_sx;
      acc_sy_upd    = acc_sy;
      acc_bb_upd    = acc_bb;
    end
  end

  // Live accumulators; every frame end clears them, accepted or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_count <= '0;
      acc_sx    <= '0;
      acc_sy    <= '0;
      acc_bb    <= BBOX_INIT;
    end else if (ce) begin
      if (frame_end) begin
        acc_count <= '0;
        acc_sx    <= '0;
        acc_sy    <= '0;
        acc_bb    <= BBOX_INIT;
      end else begin
        acc_count <= acc_count_upd;
        acc_sx    <= acc_sx_upd;
        acc_sy    <= acc_sy_upd;
        acc_bb    <= acc_bb_upd;
      end
    end
  end

  // Shadow snapshot, held stable for the whole division.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_count <= '0;
      sh_sx    <= '0;
      sh_sy    <= '0;
      sh_bb    <= BBOX_INIT;
      pending  <= 1'b0;
    end else if (ce) begin
      pending <= accept;
      if (accept) begin
        sh_count <= acc_count_upd;
        sh_sx    <= acc_sx_upd;
        sh_sy    <= acc_sy_upd;
        sh_bb    <= acc_bb_upd;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nxt = (sh_count == CNT_W'(0)) ? ST_DONE : ST_DIV_X;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV_X: state_nxt = div_done ? ST_DIV_Y : ST_DIV_X;
      ST_DIV_Y: state_nxt = div_done ? ST_DONE : ST_DIV_Y;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the Y division is launched in the cycle X completes.
  always_comb begin
    div_start    = 1'b0;
    div_dividend = sh_sx;
    cap_x        = 1'b0;
    cap_y        = 1'b0;
    publish      = 1'b0;
    case (state)
      ST_IDLE: begin
        div_start    = pending & (sh_count != CNT_W'(0));
        div_dividend = sh_sx;
      end
      ST_DIV_X: begin
        div_start    = div_done;
        div_dividend = sh_sy;
        cap_x        = div_done;
      end
      ST_DIV_Y: cap_y   = div_done;
      ST_DONE:  publish = 1'b1;
      default:  publish = 1'b0;
    endcase
  end

  mask_centroid_serial_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (sh_count),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Result registers; the centroid fits in COORD_W bits by construction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q         <= '0;
      cy_q         <= '0;
      count        <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      cx           <= '0;
      cy           <= '0;
      empty        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (ce) begin
      result_valid <= publish;
      overrun      <= frame_end & ~accept;
      if (cap_x) begin
        cx_q <= div_quotient[COORD_W-1:0];
      end
      if (cap_y) begin
        cy_q <= div_quotient[COORD_W-1:0];
      end
      if (publish) begin
        if (sh_count == CNT_W'(0)) begin
          count <= '0;
          x_min <= '0;
          x_max <= '0;
          y_min <= '0;
          y_max <= '0;
          cx    <= '0;
          cy    <= '0;
          empty <= 1'b1;
        end else begin
          count <= sh_count;
          x_min <= sh_bb.x_min;
          x_max <= sh_bb.x_max;
          y_min <= sh_bb.y_min;
          y_max <= sh_bb.y_max;
          cx    <= cx_q;
          cy    <= cy_q;
          empty <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_centroid.sv
// tb_mask_centroid
//   Directed self-checking bench for mask_centroid: reset state, several
//   mask patterns, empty frame, corner pixel, overrun, mid-division reset
//   and clock-enable toggling.
module tb_mask_centroid;

  localparam int H = 83;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        mask = 1'b0;
  logic        in_de = 1'b0;
  logic        in_vsync = 1'b0;
  logic        in_hsync = 1'b0;
  logic [19:0] count;
  logic [9:0]  x_min, x_max, y_min, y_max, cx, cy;
  logic        empty, result_valid, overrun;

  int tests = 0;
  int fails = 0;
  int pat = 0;
  bit ce_toggle = 1'b0;
  bit rv_s, ov_s;

  logic [80:0] got;
  logic [80:0] exp_v;

  mask_centroid #(.H_SIZE(83), .V_SIZE(64), .SUM_W(32)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask), .in_de(in_de),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .count(count),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .cx(cx), .cy(cy), .empty(empty), .result_valid(result_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit pix_on(int px, int py);
    case (pat)
      1: return (px >= 10 && px <= 12 && py >= 5 && py <= 7);
      2: return (px == 82 && py == 63);
      3: return (py == 0 && (px == 0 || px == 5));
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled clock; in toggle mode it is followed by a disabled clock.
  task automatic cstep();
    ce = 1'b1;
    tick();
    rv_s = result_valid;
    ov_s = overrun;
    if (ce_toggle) begin
      ce = 1'b0;
      tick();
    end
  endtask

  task automatic drive_lines(input int nlines);
    for (int ly = 0; ly < nlines; ly++) begin
      in_hsync = 1'b0;
      for (int lx = 0; lx < H; lx++) begin
        in_de = 1'b1;
        mask  = pix_on(lx, ly);
        cstep();
      end
      in_de = 1'b0;
      mask = 1'b0;
      in_hsync = 1'b1;
      cstep();
      cstep();
    end
    in_hsync = 1'b0;
  endtask

  // Vsync rise at step 0; reports first result_valid step and pulse count.
  task automatic frame_end(output int lat, output int npulse);
    in_de = 1'b0;
    mask = 1'b0;
    in_vsync = 1'b1;
    cstep();
    lat = -1;
    npulse = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 4) in_vsync = 1'b0;
      cstep();
      if (rv_s) begin
        npulse++;
        if (lat < 0) lat = k;
      end
    end
    in_vsync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #3;
    tests++;
    got = {count, x_min, x_max, y_min, y_max, cx, cy, empty};
    if (got !== 81'd0 || result_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %h rv=%b ov=%b, expected all zero", got, result_valid, overrun);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_frame(input string name, input int p, input int nlines,
                           input logic [80:0] expv, input int exp_lat);
    int lat, np;
    pat = p;
    drive_lines(nlines);
    frame_end(lat, np);
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d, expected %0d", name, lat, exp_lat);
    end
    tests++;
    if (np !== 1) begin
      fails++;
      $display("FAIL %s_pulse_count: got %0d, expected 1", name, np);
    end
    tests++;
    got = {count, x_min, x_max, y_min, y_max, cx, cy, empty};
    if (got !== expv) begin
      fails++;
      $display("FAIL %s_result: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic test_block_3x3();
    exp_v = {20'd9, 10'd10, 10'd12, 10'd5, 10'd7, 10'd11, 10'd6, 1'b0};
    run_frame("block3x3", 1, 9, exp_v, 66);
  endtask

  task automatic test_empty();
    exp_v = {20'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1};
    run_frame("empty", 0, 2, exp_v, 2);
  endtask

  task automatic test_corner();
    exp_v = {20'd1, 10'd82, 10'd82, 10'd63, 10'd63, 10'd82, 10'd63, 1'b0};
    run_frame("corner", 2, 64, exp_v, 66);
  endtask

  task automatic test_two_pixels();
    exp_v = {20'd2, 10'd0, 10'd5, 10'd0, 10'd0, 10'd2, 10'd0, 1'b0};
    run_frame("two_pixels", 3, 1, exp_v, 66);
  endtask

  task automatic test_overrun();
    int lat, ov_cnt, ov_at;
    pat = 1;
    drive_lines(9);
    in_vsync = 1'b1;
    cstep();
    lat = -1;
    ov_cnt = 0;
    ov_at = -1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 4)  in_vsync = 1'b0;
      if (k == 12) begin in_de = 1'b1; mask = 1'b1; end
      if (k == 13) begin in_de = 1'b0; mask = 1'b0; end
      if (k == 20) in_vsync = 1'b1;
      if (k == 23) in_vsync = 1'b0;
      cstep();
      if (ov_s) begin ov_cnt++; ov_at = k; end
      if (rv_s && lat < 0) lat = k;
    end
    tests++;
    if (ov_cnt !== 1 || ov_at !== 20) begin
      fails++;
      $display("FAIL overrun_pulse: got %0d pulses (last at %0d), expected 1 at 20", ov_cnt, ov_at);
    end
    tests++;
    if (lat !== 66) begin
      fails++;
      $display("FAIL overrun_first_latency: got %0d, expected 66", lat);
    end
    tests++;
    got = {count, x_min, x_max, y_min, y_max, cx, cy, empty};
    exp_v = {20'd9, 10'd10, 10'd12, 10'd5, 10'd7, 10'd11, 10'd6, 1'b0};
    if (got !== exp_v) begin
      fails++;
      $display("FAIL overrun_first_result: got %h, expected %h", got, exp_v);
    end
    // The stray pixel before the dropped frame end must not leak in.
    run_frame("after_overrun", 1, 9, exp_v, 66);
  endtask

  task automatic test_reset_mid_div();
    int rv_cnt;
    pat = 1;
    drive_lines(9);
    in_vsync = 1'b1;
    cstep();
    rv_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 4) in_vsync = 1'b0;
      cstep();
      if (rv_s) rv_cnt++;
    end
    rst = 1'b0;
    #2;
    tests++;
    got = {count, x_min, x_max, y_min, y_max, cx, cy, empty};
    if (got !== 81'd0 || result_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h rv=%b ov=%b, expected all zero", got, result_valid, overrun);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 80; k++) begin
      cstep();
      if (rv_s) rv_cnt++;
    end
    tests++;
    if (rv_cnt !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_result: got %0d pulses, expected 0", rv_cnt);
    end
    exp_v = {20'd2, 10'd0, 10'd5, 10'd0, 10'd0, 10'd2, 10'd0, 1'b0};
    run_frame("post_reset", 3, 1, exp_v, 66);
  endtask

  task automatic test_ce_toggle();
    ce_toggle = 1'b1;
    exp_v = {20'd9, 10'd10, 10'd12, 10'd5, 10'd7, 10'd11, 10'd6, 1'b0};
    run_frame("ce_toggle", 1, 9, exp_v, 66);
    ce_toggle = 1'b0;
  endtask

  initial begin
    test_reset();
    test_block_3x3();
    test_empty();
    test_corner();
    test_two_pixels();
    test_overrun();
    test_reset_mid_div();
    test_ce_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mask_centroid.md
Name: mask_centroid

Overview:
- Sink for the binary mask video stream produced by the morphological filters (mask, de, vsync, hsync).
- Per frame it accumulates foreground pixel count, coordinate sums and bounding box.
- At frame end it snapshots the totals and computes the integer centroid with a serial divider.
- It publishes one result set per frame for the tracking / overlay logic downstream.

Parameters:
- H_SIZE, 83, active pixels per line; x counter range 0..H_SIZE-1 (10-bit).
- V_SIZE, 64, active lines per frame; y counter range 0..V_SIZE-1 (10-bit).
- SUM_W, 32, width of the coordinate-sum accumulators and of the divider dividend.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when 0, all registers hold.
- mask  in  1  foreground bit, valid when in_de=1.
- in_de  in  1  active pixel strobe.
- in_vsync  in  1  frame sync, active high; rising edge marks end of frame.
- in_hsync  in  1  line sync (not used for counting; ignored).
- count  out  20  foreground pixel count of the last completed frame.
- x_min, x_max, y_min, y_max  out  10 each  bounding box of the last frame.
- cx, cy  out  10 each  floor(sum_x/count), floor(sum_y/count).
- empty  out  1  last frame had count==0.
- result_valid  out  1  one-cycle pulse when all outputs are updated.
- overrun  out  1  one-cycle pulse when a frame end arrives while dividing.

Behaviour:
- Reset (rst=0, async): all outputs 0; x=y=0; accumulators cleared; x_min/y_min=1023; x_max/y_max=0; state IDLE.
- Counting: x increments on each ce&in_de. On the falling edge of in_de (registered de_d=1, in_de=0), x←0 and y←y+1. A vsync rising edge sets x←0 and y←0.
- Accumulate on ce&in_de&mask: count+=1; sum_x+=x; sum_y+=y; min/max updated with the current x,y in the same cycle.
- Frame end is the cycle with in_vsync=1 and vsync_d=0:
  - Snapshot count, sums and bbox into shadow registers.
  - Clear the live accumulators in the same cycle.
  - A pixel accumulated in that same cycle belongs to the old frame; this cannot happen in valid video.
- FSM states IDLE, DIV_X, DIV_Y, DONE:
  - IDLE→DIV_X on frame end if shadow count≠0.
  - IDLE→DONE directly if shadow count==0; then empty=1, cx=cy=0, and bbox outputs are 0.
  - DIV_X: 32 iterations of the restoring divider (sum_x / count), then → DIV_Y.
  - DIV_Y: 32 iterations of the restoring divider (sum_y / count), then → DONE.
  - DONE: register all outputs, pulse result_valid for 1 cycle, → IDLE.
- Latency: with ce held at 1, result_valid rises 66 cycles after the frame-end cycle (1 + 32 + 32 + 1); 2 cycles when the frame is empty.
- Outputs are stable between result_valid pulses.
- Frame end while not IDLE:
  - Live accumulators are still cleared.
  - The snapshot is discarded and overrun pulses.
  - The division in progress completes unaffected.
- Quotient: the low 10 bits of the 32-bit quotient. This is exact because the centroid is always below H_SIZE/V_SIZE.
- Counter saturation: x stops at 1023 and y stops at 1023 without wrapping; no error flag.
- ce=0 mid-division freezes the iteration counter and partial remainder.

Decomposition:
- Shared package (constants):
  - COORD_W=10, CNT_W=20, DIV_ITER=32;
  - FSM state encoding;
  - BBOX_MIN_INIT=10'h3FF.
- One sub-module: serial_divider.
  - Restoring, unsigned, SUM_W-bit dividend / CNT_W-bit divisor, one quotient bit per ce cycle.
  - Ports: start, busy, done, quotient, remainder.
  - mask_centroid instantiates it once and time-shares it for X and Y.

Test Plan:
- 3x3 foreground block at x 10..12, y 5..7, H_SIZE=83, V_SIZE=64 → count=9, cx=11, cy=6, bbox (10,12,5,7), result_valid exactly 66 cycles after the vsync rise.
- All-zero frame → result_valid 2 cycles after the vsync rise, empty=1, count=0, cx=cy=0.
- Single pixel at (82,63) → cx=82, cy=63, x_min=x_max=82, y_min=y_max=63; checks the counter edges and sum widths.
- Two pixels at (0,0) and (5,0) → count=2, cx=2 (floor of 2.5), cy=0.
- Second vsync rise 20 cycles after the first (still in DIV_X) → one overrun pulse, first result still delivered at +66, and the next frame's accumulation starts from zero.
- Reset asserted mid DIV_Y → all outputs 0 immediately, no result_valid. A full frame after deassertion produces the correct result.
- ce toggling 1/0 every cycle through a full frame → same results as the 3x3 case, result_valid after 66 ce-high cycles.
